// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide sequencer that owns the HI/LO register pair.
// Each operation takes 33 cycles: WIDTH single-bit iterations, then one
// cycle that fixes the signs and writes HI/LO.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  input  logic             mfhi,
  input  logic             mflo,
  input  logic             kill,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_reg;    // |multiplicand|
  logic [WIDTH-1:0] b_reg;    // |divisor|
  logic [WIDTH-1:0] acc;      // product high half / partial remainder
  logic [WIDTH-1:0] shreg;    // multiplier -> product low half, dividend -> quotient
  logic [WIDTH-1:0] orig_a;   // dividend as issued, returned on divide by zero
  logic             is_div;
  logic             neg_q;    // product/quotient must be negated
  logic             neg_r;    // remainder must be negated

  logic             sgn_op;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   mul_sum, rem_sh, diff;
  logic             borrow;
  logic [WIDTH-1:0] acc_n, shreg_n;
  logic [2*WIDTH-1:0] prod, prod_f;
  logic [WIDTH-1:0] quot_f, rem_f;

  assign busy  = (state != S_IDLE);
  assign done  = (state == S_FIX);
  assign stall = busy & (start | mfhi | mflo | mthi | mtlo);

  // Operand magnitudes for the signed ops, raw values for the unsigned ones.
  assign sgn_op = ~op[0];
  assign a_abs  = (sgn_op && src_a[WIDTH-1]) ? -src_a : src_a;
  assign b_abs  = (sgn_op && src_b[WIDTH-1]) ? -src_b : src_b;

  // One shift-add or restoring-divide iteration on {acc, shreg}.
  always_comb begin
    mul_sum = {1'b0, acc} + (shreg[0] ? {1'b0, a_reg} : '0);
    rem_sh  = {acc, shreg[WIDTH-1]};
    diff    = rem_sh - {1'b0, b_reg};
    borrow  = diff[WIDTH];
    acc_n   = acc;
    shreg_n = shreg;
    if (state == S_MUL) begin
      acc_n   = mul_sum[WIDTH:1];
      shreg_n = {mul_sum[0], shreg[WIDTH-1:1]};
    end else if (state == S_DIV) begin
      acc_n   = borrow ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
      shreg_n = {shreg[WIDTH-2:0], ~borrow};
    end
  end

  // Sign fix-up of the finished magnitudes.
  always_comb begin
    prod   = {acc, shreg};
    prod_f = neg_q ? -prod : prod;
    quot_f = neg_q ? -shreg : shreg;
    rem_f  = neg_r ? -acc : acc;
  end

  // Sequencer, iteration datapath and HI/LO ownership.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      a_reg  <= '0;
      b_reg  <= '0;
      acc    <= '0;
      shreg  <= '0;
      orig_a <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else if (kill) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_reg  <= a_abs;
            b_reg  <= b_abs;
            acc    <= '0;
            shreg  <= op[1] ? a_abs : b_abs;
            orig_a <= src_a;
            is_div <= op[1];
            neg_q  <= sgn_op & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            neg_r  <= sgn_op & src_a[WIDTH-1];
            cnt    <= '0;
            state  <= op[1] ? S_DIV : S_MUL;
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        S_MUL, S_DIV: begin
          acc   <= acc_n;
          shreg <= shreg_n;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= S_FIX;
        end
        default: begin
          // Divide by zero bypasses the sign fix entirely.
          if (is_div && b_reg == '0) begin
            lo <= '1;
            hi <= orig_a;
          end else if (is_div) begin
            lo <= quot_f;
            hi <= rem_f;
          end else begin
            hi <= prod_f[2*WIDTH-1:WIDTH];
            lo <= prod_f[WIDTH-1:0];
          end
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed vector table,
// hand-written multi-cycle sequences, and random ops against a model.
module tb_muldiv_sequencer;
  logic        clk = 0;
  logic        rst, start, mthi, mtlo, mfhi, mflo, kill;
  logic [1:0]  op;
  logic [31:0] src_a, src_b, wdata;
  logic        busy, stall, done;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_hi, exp_lo;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .mfhi(mfhi), .mflo(mflo), .kill(kill),
    .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, eh, el;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Architectural reference using wide plain arithmetic.
  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] h, output logic [31:0] l);
    longint sa, sb, p, q, r;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: begin p = sa * sb; up = 64'(p); h = up[63:32]; l = up[31:0]; end
      2'b01: begin up = {32'b0, a} * {32'b0, b}; h = up[63:32]; l = up[31:0]; end
      2'b10: begin
        if (b == 0) begin h = a; l = '1; end
        else begin q = sa / sb; r = sa % sb; l = 32'(q); h = 32'(r); end
      end
      default: begin
        if (b == 0) begin h = a; l = '1; end
        else begin l = a / b; h = a % b; end
      end
    endcase
  endtask

  // Issue one op from IDLE and follow it to completion, checking timing and result.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int cyc, dones;
    @(negedge clk);
    start = 1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 0;
    cyc = 0; dones = 0;
    while (busy && cyc < 100) begin
      if (done) dones++;
      cyc++;
      @(negedge clk);
    end
    check({name, " busy_cycles"}, 32'(cyc), 32'd33);
    check({name, " done_pulses"}, 32'(dones), 32'd1);
    check({name, " hi"}, hi, eh);
    check({name, " lo"}, lo, el);
    exp_hi = eh; exp_lo = el;
  endtask

  initial begin
    logic [31:0] mh, ml, a, b;
    logic [1:0]  o;
    int cyc, dones;

    vecs[0] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[3] = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4] = '{2'b11, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
    vecs[5] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[6] = '{2'b10, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};

    rst = 1; start = 0; op = 0; src_a = 0; src_b = 0; wdata = 0;
    mthi = 0; mtlo = 0; mfhi = 0; mflo = 0; kill = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    check("reset stall", 32'(stall), 0);

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el);

    // mthi in IDLE writes HI only; mfhi in IDLE does not stall.
    @(negedge clk);
    mthi = 1; wdata = 32'h12345678; mfhi = 1;
    check("idle mfhi stall", 32'(stall), 0);
    @(negedge clk);
    mthi = 0; mfhi = 0;
    exp_hi = 32'h12345678;
    check("mthi hi", hi, exp_hi);
    check("mthi lo", lo, exp_lo);

    // mtlo together with start: start wins, LO not written.
    @(negedge clk);
    start = 1; mtlo = 1; wdata = 32'hDEADBEEF; op = 2'b01; src_a = 32'd6; src_b = 32'd7;
    @(negedge clk);
    start = 0; mtlo = 0;
    check("mtlo+start busy", 32'(busy), 1);
    check("mtlo+start lo", lo, exp_lo);
    cyc = 0;
    while (busy && cyc < 100) begin cyc++; @(negedge clk); end
    check("mtlo+start res lo", lo, 32'd42);
    exp_hi = 0; exp_lo = 32'd42;

    // divu in flight, then mflo and a second start held: stall throughout.
    @(negedge clk);
    start = 1; op = 2'b11; src_a = 32'd100; src_b = 32'd7;
    @(negedge clk);
    start = 1; mflo = 1; op = 2'b01; src_a = 32'h00010000; src_b = 32'h00030000;
    cyc = 0; dones = 0;
    while (busy && cyc < 100) begin
      if (!stall) dones++;
      cyc++;
      @(negedge clk);
    end
    check("hold stall gaps", 32'(dones), 0);
    check("hold busy_cycles", 32'(cyc), 32'd33);
    check("hold idle stall", 32'(stall), 0);
    check("hold first hi", hi, 32'd2);
    check("hold first lo", lo, 32'd14);
    @(negedge clk);
    check("hold second accepted", 32'(busy), 1);
    start = 0; mflo = 0;
    cyc = 0;
    while (busy && cyc < 100) begin cyc++; @(negedge clk); end
    check("hold second hi", hi, 32'h00000003);
    check("hold second lo", lo, 32'h00000000);
    exp_hi = 32'h3; exp_lo = 0;

    // kill at iteration 10.
    @(negedge clk);
    start = 1; op = 2'b00; src_a = 32'd5; src_b = 32'd9;
    @(negedge clk);
    start = 0;
    dones = 0;
    repeat (10) begin if (done) dones++; @(negedge clk); end
    kill = 1;
    @(negedge clk);
    kill = 0;
    check("kill busy", 32'(busy), 0);
    check("kill hi", hi, exp_hi);
    check("kill lo", lo, exp_lo);
    repeat (40) begin if (done) dones++; @(negedge clk); end
    check("kill done", 32'(dones), 0);
    check("kill hold hi", hi, exp_hi);

    // kill in IDLE blocks start.
    start = 1; kill = 1; op = 2'b01; src_a = 1; src_b = 1;
    @(negedge clk);
    start = 0; kill = 0;
    check("idle kill blocks start", 32'(busy), 0);

    // reset mid-operation.
    start = 1; op = 2'b11; src_a = 32'd50; src_b = 32'd3;
    @(negedge clk);
    start = 0;
    repeat (5) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("midrst hi", hi, 0);
    check("midrst lo", lo, 0);
    check("midrst busy", 32'(busy), 0);

    // Random operations against the model, with some corner operands.
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 0;
        1: b = 32'hFFFFFFFF;
        2: a = 32'h80000000;
        3: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      model(o, a, b, mh, ml);
      run_op($sformatf("rnd%0d op%0d %h %h", i, o, a, b), o, a, b, mh, ml);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
